// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC generation, a single-line buffer, the I-cache request
// handshake and an in-order FWFT queue of {order, pc, inst} toward decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'haaaaa000,
    parameter int          QDEPTH     = 16,
    parameter int          LINE_BYTES = 32,
    parameter int          ORDER_W    = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        redirect_valid_i,
    input  logic [31:0]                 redirect_pc_i,
    input  logic [ORDER_W-1:0]          redirect_order_i,
    output logic [31:0]                 imem_addr_o,
    output logic [3:0]                  imem_rmask_o,
    input  logic [8*LINE_BYTES-1:0]     imem_rline_i,
    input  logic                        imem_resp_i,
    output logic                        deq_valid_o,
    input  logic                        deq_ready_i,
    output logic [31:0]                 deq_inst_o,
    output logic [31:0]                 deq_pc_o,
    output logic [ORDER_W-1:0]          deq_order_o,
    output logic [$clog2(QDEPTH):0]     q_count_o
);

    localparam int LW  = 8 * LINE_BYTES;
    localparam int OFF = $clog2(LINE_BYTES);
    localparam int PW  = $clog2(QDEPTH);
    localparam int CW  = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [ORDER_W-1:0]   order_q, order_d;
    logic [31:0]          req_addr_q, req_addr_d;
    logic                 lb_valid_q, lb_valid_d;
    logic [31-OFF:0]      lb_tag_q, lb_tag_d;
    logic [LW-1:0]        lb_data_q, lb_data_d;
    logic [31:0]          imem_addr_d;
    logic [3:0]           imem_rmask_d;

    logic [31:0]          q_inst_q  [QDEPTH];
    logic [31:0]          q_pc_q    [QDEPTH];
    logic [ORDER_W-1:0]   q_order_q [QDEPTH];
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]        count_q, count_d;

    logic                 hit_s;
    logic                 full_s;
    logic                 enq_s;
    logic                 fire_s;
    logic                 deq_valid_s;
    logic [31:0]          word_s;

    assign hit_s       = lb_valid_q && (lb_tag_q == pc_q[31:OFF]);
    assign word_s      = lb_data_q[32*pc_q[OFF-1:2] +: 32];
    assign full_s      = (count_q == CW'(QDEPTH));
    assign deq_valid_s = (count_q != {CW{1'b0}}) && !redirect_valid_i;
    assign fire_s      = deq_valid_s && deq_ready_i;

    // Fetch FSM next state, line-buffer fill and registered cache request outputs
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        order_d    = order_q;
        req_addr_d = req_addr_q;
        lb_valid_d = lb_valid_q;
        lb_tag_d   = lb_tag_q;
        lb_data_d  = lb_data_q;
        enq_s      = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (redirect_valid_i) begin
                    state_d = ST_RUN;
                end else if (!hit_s) begin
                    req_addr_d = pc_q;
                    state_d    = ST_WAIT;
                end else if (!full_s) begin
                    enq_s   = 1'b1;
                    pc_d    = pc_q + 32'd4;
                    order_d = order_q + ORDER_W'(1);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT, ST_DISCARD: begin
                // The returned line is genuine even when the request went stale.
                if (imem_resp_i) begin
                    lb_valid_d = 1'b1;
                    lb_tag_d   = req_addr_q[31:OFF];
                    lb_data_d  = imem_rline_i;
                    state_d    = ST_RUN;
                end else if (redirect_valid_i) begin
                    state_d = ST_DISCARD;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        if (redirect_valid_i) begin
            pc_d    = redirect_pc_i & 32'hffff_fffc;
            order_d = redirect_order_i;
        end else begin
            pc_d    = pc_d;
        end
        if (state_d != ST_RUN) begin
            imem_rmask_d = 4'hf;
            imem_addr_d  = req_addr_d;
        end else begin
            imem_rmask_d = 4'h0;
            imem_addr_d  = 32'h0;
        end
    end

    // Queue pointer and occupancy next state; a redirect empties the queue
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (redirect_valid_i) begin
            rd_ptr_d = {PW{1'b0}};
            wr_ptr_d = {PW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (enq_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (fire_s) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({enq_s, fire_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control and line-buffer state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            order_q      <= {ORDER_W{1'b0}};
            req_addr_q   <= 32'h0;
            lb_valid_q   <= 1'b0;
            lb_tag_q     <= {(32-OFF){1'b0}};
            lb_data_q    <= {LW{1'b0}};
            imem_addr_o  <= 32'h0;
            imem_rmask_o <= 4'h0;
            rd_ptr_q     <= {PW{1'b0}};
            wr_ptr_q     <= {PW{1'b0}};
            count_q      <= {CW{1'b0}};
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            order_q      <= order_d;
            req_addr_q   <= req_addr_d;
            lb_valid_q   <= lb_valid_d;
            lb_tag_q     <= lb_tag_d;
            lb_data_q    <= lb_data_d;
            imem_addr_o  <= imem_addr_d;
            imem_rmask_o <= imem_rmask_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
        end
    end

    // Queue storage write port
    always_ff @(posedge clk) begin
        if (!rst && enq_s) begin
            q_inst_q[wr_ptr_q]  <= word_s;
            q_pc_q[wr_ptr_q]    <= pc_q;
            q_order_q[wr_ptr_q] <= order_q;
        end
    end

    assign deq_valid_o = deq_valid_s;
    assign deq_inst_o  = q_inst_q[rd_ptr_q];
    assign deq_pc_o    = q_pc_q[rd_ptr_q];
    assign deq_order_o = q_order_q[rd_ptr_q];
    assign q_count_o   = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a behavioural I-cache with configurable latency plus an
// in-order stream model (sequential pc/order restarting at every redirect).
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'haaaaa000;
    localparam int QDEPTH = 16;
    localparam int LW = 256;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               redirect_valid = 1'b0;
    logic [31:0]        redirect_pc = 32'h0;
    logic [63:0]        redirect_order = 64'h0;
    logic [31:0]        imem_addr_o;
    logic [3:0]         imem_rmask_o;
    logic [LW-1:0]      imem_rline = '0;
    logic               imem_resp = 1'b0;
    logic               deq_valid_o;
    logic               deq_ready = 1'b0;
    logic [31:0]        deq_inst_o;
    logic [31:0]        deq_pc_o;
    logic [63:0]        deq_order_o;
    logic [4:0]         q_count_o;

    fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH), .LINE_BYTES(32), .ORDER_W(64)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid_i(redirect_valid), .redirect_pc_i(redirect_pc),
        .redirect_order_i(redirect_order),
        .imem_addr_o(imem_addr_o), .imem_rmask_o(imem_rmask_o),
        .imem_rline_i(imem_rline), .imem_resp_i(imem_resp),
        .deq_valid_o(deq_valid_o), .deq_ready_i(deq_ready),
        .deq_inst_o(deq_inst_o), .deq_pc_o(deq_pc_o), .deq_order_o(deq_order_o),
        .q_count_o(q_count_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          last_resp_cyc = 0;
    int          wait_cnt = 0;
    int          resp_delay = 3;
    bit          auto_resp = 1'b1;
    bit          force_resp = 1'b0;
    bit          rand_delay = 1'b0;
    logic [31:0] cur_req = 32'h0;
    logic [31:0] seed = 32'h0;
    logic [31:0] req_log [$];
    logic [31:0] exp_pc = RESET_PC;
    logic [63:0] exp_order = 64'h0;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9e3779b1) ^ seed;
    endfunction

    // One clock cycle: cache model reacts, outputs are checked, then the edge passes.
    task automatic cycle();
        logic [31:0] base;
        imem_resp = 1'b0;
        if (imem_rmask_o == 4'hf) begin
            if (wait_cnt == 0) begin
                req_log.push_back(imem_addr_o);
                cur_req = imem_addr_o;
                if (rand_delay) resp_delay = $urandom_range(0, 4);
            end else begin
                checks++;
                if (imem_addr_o !== cur_req) begin
                    errors++;
                    $display("FAIL req_stable: imem_addr=%h required %h", imem_addr_o, cur_req);
                end
            end
            wait_cnt++;
            if (force_resp || (auto_resp && wait_cnt > resp_delay)) begin
                imem_resp = 1'b1;
                base = {cur_req[31:5], 5'b0};
                for (int i = 0; i < 8; i++) imem_rline[32*i +: 32] = memfn(base + 32'(4*i));
                last_resp_cyc = cyc;
            end
        end else begin
            wait_cnt = 0;
        end
        #1;
        if (redirect_valid) begin
            checks++;
            if (deq_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL redirect_deq_valid: got %b required 0", deq_valid_o);
            end
        end
        if (deq_valid_o === 1'b1 && deq_ready) begin
            checks++;
            if (deq_pc_o !== exp_pc || deq_order_o !== exp_order || deq_inst_o !== memfn(exp_pc)) begin
                errors++;
                $display("FAIL deq_entry: pc=%h order=%h inst=%h required pc=%h order=%h inst=%h",
                         deq_pc_o, deq_order_o, deq_inst_o, exp_pc, exp_order, memfn(exp_pc));
            end
            exp_pc = exp_pc + 32'd4;
            exp_order = exp_order + 64'd1;
        end
        if (redirect_valid) begin
            exp_pc = {redirect_pc[31:2], 2'b00};
            exp_order = redirect_order;
        end
        if (q_count_o > 5'(QDEPTH)) begin
            checks++;
            errors++;
            $display("FAIL q_count_bound: got %0d required <= %0d", q_count_o, QDEPTH);
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        force_resp = 1'b0;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        deq_ready = 1'b0;
        redirect_valid = 1'b0;
        imem_resp = 1'b0;
        repeat (2) @(negedge clk);
        wait_cnt = 0;
        req_log.delete();
        exp_pc = RESET_PC;
        exp_order = 64'h0;
        auto_resp = 1'b1;
        rand_delay = 1'b0;
        rst = 1'b0;
    endtask

    task automatic do_redirect(input logic [31:0] pc, input logic [63:0] ord);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        redirect_order = ord;
        cycle();
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset_q_count", 64'(q_count_o), 64'd0);
        check_val("reset_deq_valid", 64'(deq_valid_o), 64'd0);
        check_val("reset_rmask", 64'(imem_rmask_o), 64'd0);
        check_val("reset_addr", 64'(imem_addr_o), 64'd0);
        do_reset();
    endtask

    task automatic test_first_fetch();
        do_reset();
        resp_delay = 3;
        for (int i = 0; i < 50 && q_count_o == 5'd0; i++) cycle();
        check_val("miss_penalty", 64'(cyc), 64'(last_resp_cyc + 2));
        for (int i = 0; i < 100 && req_log.size() < 2; i++) cycle();
        check_val("req_count", 64'(req_log.size()), 64'd2);
        if (req_log.size() >= 2) begin
            check_val("req0_addr", 64'(req_log[0]), 64'haaaaa000);
            check_val("req1_addr", 64'(req_log[1]), 64'haaaaa020);
        end
        check_val("line_enqueues", 64'(q_count_o), 64'd8);
        deq_ready = 1'b1;
        repeat (30) cycle();
        checks++;
        if (exp_order < 64'd8) begin
            errors++;
            $display("FAIL first_drain: order reached %0d required >= 8", exp_order);
        end
    endtask

    task automatic test_full();
        do_reset();
        resp_delay = 3;
        for (int i = 0; i < 300 && q_count_o != 5'(QDEPTH); i++) cycle();
        check_val("full_count", 64'(q_count_o), 64'(QDEPTH));
        repeat (20) cycle();
        check_val("full_hold", 64'(q_count_o), 64'(QDEPTH));
        check_val("full_req_count", 64'(req_log.size()), 64'd3);
        check_val("full_last_req", 64'(req_log[req_log.size()-1]), 64'haaaaa040);
        deq_ready = 1'b1;
        cycle();
        deq_ready = 1'b0;
        check_val("single_fire", 64'(q_count_o), 64'(QDEPTH - 1));
        cycle();
        check_val("refill_one", 64'(q_count_o), 64'(QDEPTH));
        cycle();
        check_val("refill_hold", 64'(q_count_o), 64'(QDEPTH));
        deq_ready = 1'b1;
        repeat (40) cycle();
        checks++;
        if (exp_order < 64'd17) begin
            errors++;
            $display("FAIL full_drain: order reached %0d required >= 17", exp_order);
        end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        resp_delay = 6;
        for (int i = 0; i < 20 && imem_rmask_o != 4'hf; i++) cycle();
        do_redirect(32'h0000_1002, 64'd50);
        for (int i = 0; i < 50 && req_log.size() < 2; i++) begin
            check_val("discard_no_enq", 64'(q_count_o), 64'd0);
            cycle();
        end
        check_val("redir_req_count", 64'(req_log.size()), 64'd2);
        if (req_log.size() >= 2) check_val("redir_req_addr", 64'(req_log[1]), 64'h1000);
        for (int i = 0; i < 50 && !deq_valid_o; i++) cycle();
        check_val("redir_first_order", deq_order_o, 64'd50);
        check_val("redir_first_pc", 64'(deq_pc_o), 64'h1000);
        deq_ready = 1'b1;
        repeat (20) cycle();
    endtask

    task automatic test_redirect_flush();
        do_reset();
        resp_delay = 2;
        for (int i = 0; i < 50 && q_count_o != 5'd5; i++) cycle();
        check_val("pre_flush_count", 64'(q_count_o), 64'd5);
        deq_ready = 1'b1;
        do_redirect(32'hffff_ffe0 + 32'(4 * $urandom_range(0, 7)), 64'hffff_ffff_ffff_fffe);
        check_val("flush_count", 64'(q_count_o), 64'd0);
        repeat (60) cycle();
        checks++;
        if (exp_order == 64'hffff_ffff_ffff_fffe || exp_order > 64'd100) begin
            errors++;
            $display("FAIL order_wrap: order now %h required wrapped small value", exp_order);
        end
    endtask

    task automatic test_redirect_in_line();
        int n;
        do_reset();
        resp_delay = 2;
        for (int i = 0; i < 50 && q_count_o != 5'd3; i++) cycle();
        n = req_log.size();
        do_redirect(32'haaaaa014, 64'd7);
        check_val("inline_flush", 64'(q_count_o), 64'd0);
        cycle();
        check_val("inline_count", 64'(q_count_o), 64'd1);
        check_val("inline_pc", 64'(deq_pc_o), 64'haaaaa014);
        check_val("inline_inst", 64'(deq_inst_o), 64'(memfn(32'haaaaa014)));
        check_val("inline_order", deq_order_o, 64'd7);
        check_val("inline_no_req", 64'(req_log.size()), 64'(n));
        check_val("inline_rmask", 64'(imem_rmask_o), 64'd0);
    endtask

    task automatic test_resp_redirect();
        int n;
        do_reset();
        auto_resp = 1'b0;
        for (int i = 0; i < 20 && imem_rmask_o != 4'hf; i++) cycle();
        cycle();
        cycle();
        n = req_log.size();
        force_resp = 1'b1;
        do_redirect(32'haaaaa008, 64'd100);
        check_val("resp_redir_rmask", 64'(imem_rmask_o), 64'd0);
        check_val("resp_redir_no_enq", 64'(q_count_o), 64'd0);
        cycle();
        check_val("resp_redir_count", 64'(q_count_o), 64'd1);
        check_val("resp_redir_pc", 64'(deq_pc_o), 64'haaaaa008);
        check_val("resp_redir_inst", 64'(deq_inst_o), 64'(memfn(32'haaaaa008)));
        check_val("resp_redir_order", deq_order_o, 64'd100);
        check_val("resp_redir_no_req", 64'(req_log.size()), 64'(n));
        auto_resp = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        rand_delay = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            deq_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) begin
                redirect_valid = 1'b1;
                redirect_pc = ($urandom_range(0, 1) == 0) ? $urandom : exp_pc + 32'(4 * $urandom_range(0, 12));
                redirect_order = {$urandom, $urandom};
            end
            cycle();
        end
        deq_ready = 1'b1;
        repeat (60) cycle();
        check_val("random_drained_count", 64'(q_count_o <= 5'(QDEPTH)), 64'd1);
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_first_fetch();
        test_full();
        test_redirect_wait();
        test_redirect_flush();
        test_redirect_in_line();
        test_resp_redirect();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
